// File: rtl/reg_file_scb_if.sv
// rtl/reg_file_scb_if.sv - decode/issue/writeback port bundle for reg_file_scb
interface reg_file_scb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ready;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;

    modport master (
        input  ready, rd_data1, rd_data2, rd_busy1, rd_busy2,
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr
    );

    modport slave (
        output ready, rd_data1, rd_data2, rd_busy1, rd_busy2,
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr
    );
endinterface

// File: rtl/reg_file_scb.sv
// rtl/reg_file_scb.sv - register file with busy scoreboard and post-reset clear; optional write bypass via REG_FILE_SCB_BYPASS_EN
module reg_file_scb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    reg_file_scb_if.slave  io_bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ready;
    logic              w_wr_ok;
    logic              w_issue_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Register 0 is hard-wired when ZERO_REG is set: no writes, no busy, reads 0.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_ready    = (r_state == S_READY);
    assign w_wr_ok    = w_ready && io_bus.wr_en    && !is_zero_reg(io_bus.wr_addr);
    assign w_issue_ok = w_ready && io_bus.issue_en && !is_zero_reg(io_bus.issue_addr);
    assign io_bus.ready = w_ready;

    // State and clear pointer; reset restarts the clear sequence from entry 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // Next state: walk every entry once, leave CLEAR on the edge that zeroes the last one.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            S_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                w_state_nxt = S_READY;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // Single array write port shared by the clear sequencer and writeback.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (!w_ready) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_ptr;
            w_mem_wdata = '0;
        end else if (w_wr_ok) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = io_bus.wr_addr;
            w_mem_wdata = io_bus.wr_data;
        end
    end

    // Array storage carries no reset; the clear sequencer zeroes it instead.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Scoreboard update: writeback clears, issue sets afterwards so a new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[io_bus.wr_addr] = 1'b0;
        end
        if (w_issue_ok) begin
            w_busy_nxt[io_bus.issue_addr] = 1'b1;
        end
    end

    // Scoreboard register, cleared asynchronously by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read port 1: zero while clearing or for register 0, optional same-cycle writeback forward.
    always_comb begin
        io_bus.rd_data1 = '0;
        io_bus.rd_busy1 = 1'b0;
        if (w_ready && !is_zero_reg(io_bus.rd_addr1)) begin
            io_bus.rd_data1 = r_mem[io_bus.rd_addr1];
            io_bus.rd_busy1 = r_busy[io_bus.rd_addr1];
`ifdef REG_FILE_SCB_BYPASS_EN
            if (w_wr_ok && (io_bus.wr_addr == io_bus.rd_addr1)) begin
                io_bus.rd_data1 = io_bus.wr_data;
                io_bus.rd_busy1 = 1'b0;
            end
`else
`endif
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        io_bus.rd_data2 = '0;
        io_bus.rd_busy2 = 1'b0;
        if (w_ready && !is_zero_reg(io_bus.rd_addr2)) begin
            io_bus.rd_data2 = r_mem[io_bus.rd_addr2];
            io_bus.rd_busy2 = r_busy[io_bus.rd_addr2];
`ifdef REG_FILE_SCB_BYPASS_EN
            if (w_wr_ok && (io_bus.wr_addr == io_bus.rd_addr2)) begin
                io_bus.rd_data2 = io_bus.wr_data;
                io_bus.rd_busy2 = 1'b0;
            end
`else
`endif
        end
    end
endmodule

// File: doc/reg_file_scb.md
# reg_file_scb

Parametrised successor to the pipeline register file: two combinational read ports, one synchronous write port, a per-register busy scoreboard for hazard detection, and a self-clearing sequencer that zeroes the array after reset. Sits in the decode stage of the data path; decode reads operands and busy flags, issue marks destinations pending, and writeback writes results and clears pending bits.

## Interface

- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and never becomes busy
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears sequencer and scoreboard
- ready  output  1  1 once the post-reset clear sequence has finished
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data
- rd_data2  output  DATA_W  read port 2 data
- rd_busy1  output  1  scoreboard bit for rd_addr1
- rd_busy2  output  1  scoreboard bit for rd_addr2
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback address
- wr_data  input  DATA_W  writeback data
- issue_en  input  1  mark issue_addr as pending
- issue_addr  input  ADDR_W  destination of issued instruction

## Operation

- Two states: CLEAR, READY. Reset forces CLEAR, clr_ptr = 0, all busy bits = 0, ready = 0.
- CLEAR: each rising edge writes 0 to mem[clr_ptr] and increments clr_ptr; the edge that writes DEPTH-1 moves to READY. wr_en and issue_en are ignored; rd_data* = 0, rd_busy* = 0.
- READY: rising edge with wr_en writes mem[wr_addr] = wr_data and clears busy[wr_addr]; rising edge with issue_en sets busy[issue_addr].
- Same-edge issue_en and wr_en to the same address: data is written, busy ends 1 (new producer wins).
- ZERO_REG = 1 and address 0: write, issue and busy set suppressed; rd_data = 0, rd_busy = 0.
- Reads are combinational from the array and the busy vector; both ports may address the same register.
- Reset asserted mid-operation, including mid-CLEAR: immediate return to CLEAR, clr_ptr restarts at 0, busy cleared; array contents are undefined until clear completes.
- Array has no reset; zeroing is done only by the sequencer.

## Timing

- Read latency 0 cycles (combinational from address).
- Write visible on reads the cycle after the wr_en edge (same cycle with bypass, see Configuration).
- Busy set visible the cycle after the issue_en edge; busy clear follows write timing.
- ready rises DEPTH rising edges after reset deasserts (32 with defaults) and stays 1 until next reset.
- Reset to ready = 0, rd_data* = 0, rd_busy* = 0 is asynchronous, with no clock required.

## Configuration

- REG_FILE_SCB_BYPASS_EN defined: in READY, if wr_en and wr_addr == rd_addrN (and not suppressed register 0), rd_dataN = wr_data and rd_busyN = 0 in the same cycle. A same-cycle issue_en to that address does not affect the bypassed busy.
- Not defined: no forwarding; reads return registered array and busy contents only.

## Test plan

- Deassert reset, hold wr_en = 1 to addr 3 -> ready = 0 for 32 cycles and then 1; all 32 registers read 0; the ignored write leaves reg 3 = 0.
- READY: write 0xDEADBEEF to reg 5, then read via both ports next cycle -> both ports return 0xDEADBEEF. Write 0x1 to reg 0 -> reg 0 reads 0.
- issue_en to reg 7 -> rd_busy = 1 next cycle. wr_en reg 7 = 0x55 -> busy 0 and data 0x55 next cycle. Same-edge issue and write on reg 9 -> busy = 1 and data updated.
- Bypass build: wr_en reg 12 = 0xA5A5A5A5 with rd_addr1 = 12 and busy[12] = 1 -> same cycle rd_data1 = 0xA5A5A5A5, rd_busy1 = 0. Non-bypass build -> old data, busy 1.
- Assert reset at clear cycle 10 for 1 cycle -> ready stays 0 for a full 32 cycles after deassert; a busy set before reset reads 0.
- Assert reset asynchronously in READY between edges -> ready, rd_busy* and rd_data* drop to 0 before the next clk edge.
